// File: rtl/hh_pkg.sv
// Shared types and constants for the HH spike decoder: voltage width,
// detector state encoding and the ISI counter ceiling.
package hh_pkg;

    localparam int HH_V_W = 14;

    typedef enum logic [1:0] {
        BELOW   = 2'd0,
        ABOVE   = 2'd1,
        REFRACT = 2'd2
    } hh_state_t;

    // Highest value the running ISI counter may hold; the pushed ISI is one more.
    function automatic int unsigned isi_sat_max(input int unsigned w);
        return (32'd1 << w) - 32'd2;
    endfunction

endpackage

// File: rtl/hh_isi_fifo.sv
// Show-ahead ISI FIFO: head is valid whenever the FIFO is non-empty and a
// push into a full FIFO is accepted only when a pop frees a slot the same cycle.
module hh_isi_fifo #(
    parameter int ISI_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [ISI_W-1:0] push_data,
    input  logic             pop,
    output logic [ISI_W-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [ISI_W-1:0] mem [0:FIFO_DEPTH-1];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_en;
    logic             rd_en;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/hh_spike_decoder.sv
// Turns the HH membrane-voltage stream into spike pulses with hysteresis and
// refractory hold-off, and queues inter-spike intervals (in samples).
module hh_spike_decoder
    import hh_pkg::*;
#(
    parameter int V_W         = HH_V_W,
    parameter int ISI_W       = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int TH_HI       = 500,
    parameter int TH_LO       = -500,
    parameter int REFRACT_CYC = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic signed [V_W-1:0] v_in,
    input  logic                  sample_en,
    output logic                  spike_o,
    output logic [7:0]            spike_cnt,
    output logic [ISI_W-1:0]      isi_data,
    output logic                  isi_valid,
    input  logic                  isi_ready,
    output logic                  ovf,
    input  logic                  ovf_clr
);

    localparam logic signed [V_W-1:0] TH_HI_V = V_W'(TH_HI);
    localparam logic signed [V_W-1:0] TH_LO_V = V_W'(TH_LO);
    localparam int                   RC_W     = (REFRACT_CYC < 2) ? 1 : $clog2(REFRACT_CYC + 1);
    localparam logic [RC_W-1:0]      RC_LOAD  = RC_W'(REFRACT_CYC);
    localparam logic [ISI_W-1:0]     ISI_CEIL = ISI_W'(isi_sat_max(ISI_W));

    hh_state_t        state_p0;
    logic [RC_W-1:0]  rcnt_p0;
    logic [ISI_W-1:0] isi_cnt_p0;
    logic             first_seen;
    logic             fire_p0;
    logic             spike_p1;
    logic             push_p1;
    logic [ISI_W-1:0] push_data_p1;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;

    assign fire_p0 = sample_en && (state_p0 == BELOW) && (v_in >= TH_HI_V);

    // Stage p0: detector state machine, advances only on valid samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p0 <= BELOW;
            rcnt_p0  <= '0;
        end else if (sample_en) begin
            case (state_p0)
                BELOW: begin
                    if (v_in >= TH_HI_V) state_p0 <= ABOVE;
                end
                ABOVE: begin
                    if (v_in < TH_LO_V) begin
                        if (REFRACT_CYC == 0) begin
                            state_p0 <= BELOW;
                        end else begin
                            state_p0 <= REFRACT;
                            rcnt_p0  <= RC_LOAD;
                        end
                    end
                end
                REFRACT: begin
                    rcnt_p0 <= rcnt_p0 - RC_W'(1);
                    if (rcnt_p0 <= RC_W'(1)) state_p0 <= BELOW;
                end
                default: state_p0 <= BELOW;
            endcase
        end
    end

    // Stage p0 -> p1: spike pulse, spike count, ISI counter and overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            isi_cnt_p0 <= '0;
            first_seen <= 1'b0;
            spike_p1   <= 1'b0;
            push_p1    <= 1'b0;
            spike_cnt  <= '0;
            ovf        <= 1'b0;
        end else begin
            spike_p1 <= fire_p0;
            push_p1  <= fire_p0 && first_seen;
            if (fire_p0) begin
                isi_cnt_p0 <= '0;
                first_seen <= 1'b1;
                spike_cnt  <= spike_cnt + 8'd1;
            end else if (sample_en && (isi_cnt_p0 < ISI_CEIL)) begin
                isi_cnt_p0 <= isi_cnt_p0 + ISI_W'(1);
            end
            if (push_p1 && fifo_full && !pop) ovf <= 1'b1;
            else if (ovf_clr)                 ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (fire_p0) push_data_p1 <= isi_cnt_p0 + ISI_W'(1);
    end

    assign spike_o   = spike_p1;
    assign isi_valid = !fifo_empty;
    assign pop       = isi_valid && isi_ready;

    // Stage p1 -> p2: ISI queue, head visible the cycle after the push
    hh_isi_fifo #(
        .ISI_W      (ISI_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_isi_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_p1),
        .push_data (push_data_p1),
        .pop       (pop),
        .head      (isi_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_hh_spike_decoder.sv
// Directed bench for hh_spike_decoder with hand-computed spike and ISI expectations.
module tb_hh_spike_decoder;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [13:0] v_in = '0;
    logic               sample_en = 1'b0;
    logic               spike_o;
    logic [7:0]         spike_cnt;
    logic [15:0]        isi_data;
    logic               isi_valid;
    logic               isi_ready = 1'b0;
    logic               ovf;
    logic               ovf_clr = 1'b0;

    int total = 0;
    int bad   = 0;

    hh_spike_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .v_in      (v_in),
        .sample_en (sample_en),
        .spike_o   (spike_o),
        .spike_cnt (spike_cnt),
        .isi_data  (isi_data),
        .isi_valid (isi_valid),
        .isi_ready (isi_ready),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One valid sample; returns #1 after the edge that captured it.
    task automatic smp(input int v);
        v_in      = v[13:0];
        sample_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        sample_en = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        sample_en = 1'b0;
        isi_ready = 1'b0;
        ovf_clr   = 1'b0;
        v_in      = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Spike, re-arm, then g quiet samples: next spike lands 2+g samples later.
    task automatic gen_spike(input int g);
        smp(600);
        smp(-600);
        repeat (g) smp(0);
    endtask

    initial begin
        int acc_spk, acc_vld, acc_ovf, v;
        int drain_exp [4];

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        chk("rst_spike", 32'(spike_o), 0);
        chk("rst_cnt", 32'(spike_cnt), 0);
        chk("rst_valid", 32'(isi_valid), 0);
        chk("rst_ovf", 32'(ovf), 0);
        rst_n = 1'b1;
        acc_spk = 0; acc_vld = 0; acc_ovf = 0;
        repeat (50) begin
            smp(-1000);
            acc_spk += int'(spike_o);
            acc_vld += int'(isi_valid);
            acc_ovf += int'(ovf);
        end
        chk("idle_spikes", 32'(acc_spk), 0);
        chk("idle_valid", 32'(acc_vld), 0);
        chk("idle_ovf", 32'(acc_ovf), 0);
        chk("idle_cnt", 32'(spike_cnt), 0);

        // Hysteresis: only the first 600 fires until a sample below -500
        smp(600);
        chk("hys_spike1", 32'(spike_o), 1);
        chk("hys_cnt1", 32'(spike_cnt), 1);
        acc_spk = 0;
        smp(400);  acc_spk += int'(spike_o);
        smp(600);  acc_spk += int'(spike_o);
        smp(400);  acc_spk += int'(spike_o);
        smp(600);  acc_spk += int'(spike_o);
        chk("hys_no_refire", 32'(acc_spk), 0);
        chk("hys_cnt_hold", 32'(spike_cnt), 1);
        repeat (9) smp(-600);
        smp(600);
        chk("hys_spike2", 32'(spike_o), 1);
        chk("hys_cnt2", 32'(spike_cnt), 2);
        chk("hys_push_lat", 32'(isi_valid), 0);
        idle(1);
        chk("hys_isi_valid", 32'(isi_valid), 1);
        chk("hys_isi", 32'(isi_data), 14);

        // ISI and latency: spikes at samples 10, 30, 55
        do_reset();
        isi_ready = 1'b1;
        for (int i = 0; i < 70; i++) begin
            if (i == 10 || i == 30 || i == 55)      v = 600;
            else if (i == 11 || i == 31 || i == 56) v = -600;
            else                                    v = 0;
            smp(v);
            chk($sformatf("isi_spike_%0d", i), 32'(spike_o), 32'(i == 10 || i == 30 || i == 55));
            chk($sformatf("isi_valid_%0d", i), 32'(isi_valid), 32'(i == 31 || i == 56));
            if (i == 31) chk("isi_first", 32'(isi_data), 20);
            if (i == 56) chk("isi_second", 32'(isi_data), 25);
        end
        chk("isi_cnt", 32'(spike_cnt), 3);

        // Refractory hold-off
        do_reset();
        smp(600);
        smp(-600);
        acc_spk = 0;
        repeat (8) begin
            smp(700);
            acc_spk += int'(spike_o);
        end
        chk("ref_blocked", 32'(acc_spk), 0);
        smp(700);
        chk("ref_9th_spike", 32'(spike_o), 1);
        idle(1);
        chk("ref_isi_valid", 32'(isi_valid), 1);
        chk("ref_isi", 32'(isi_data), 10);

        // FIFO full and overflow
        do_reset();
        gen_spike(8);
        gen_spike(9);
        gen_spike(10);
        gen_spike(11);
        gen_spike(12);
        chk("full_no_ovf", 32'(ovf), 0);
        gen_spike(13);
        chk("full_ovf_set", 32'(ovf), 1);
        chk("full_valid", 32'(isi_valid), 1);
        chk("full_head", 32'(isi_data), 10);
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(ovf), 0);
        smp(600);
        isi_ready = 1'b1;
        smp(-600);
        isi_ready = 1'b0;
        idle(1);
        chk("full_pop_push_ovf", 32'(ovf), 0);
        drain_exp = '{11, 12, 13, 15};
        isi_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain_valid_%0d", k), 32'(isi_valid), 1);
            chk($sformatf("drain_data_%0d", k), 32'(isi_data), 32'(drain_exp[k]));
            @(posedge clk);
            #1;
        end
        chk("drain_empty", 32'(isi_valid), 0);
        isi_ready = 1'b0;

        // sample_en at 50 %: ISI counted in samples
        do_reset();
        smp(600);
        chk("gate_spike", 32'(spike_o), 1);
        idle(1);
        chk("gate_pulse_one", 32'(spike_o), 0);
        smp(-600);
        idle(1);
        repeat (8) begin
            smp(0);
            idle(1);
        end
        smp(600);
        idle(2);
        chk("gate_valid", 32'(isi_valid), 1);
        chk("gate_isi", 32'(isi_data), 10);
        chk("gate_cnt", 32'(spike_cnt), 2);

        // Async reset mid-refractory with two entries queued
        do_reset();
        gen_spike(8);
        gen_spike(8);
        smp(600);
        smp(-600);
        repeat (3) smp(0);
        chk("pre_rst_valid", 32'(isi_valid), 1);
        chk("pre_rst_cnt", 32'(spike_cnt), 3);
        sample_en = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("arst_spike", 32'(spike_o), 0);
        chk("arst_cnt", 32'(spike_cnt), 0);
        chk("arst_valid", 32'(isi_valid), 0);
        chk("arst_data", 32'(isi_data), 0);
        chk("arst_ovf", 32'(ovf), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        smp(600);
        chk("post_rst_spike", 32'(spike_o), 1);
        chk("post_rst_cnt", 32'(spike_cnt), 1);
        idle(2);
        chk("post_rst_no_push", 32'(isi_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hh_spike_decoder.md
Name: hh_spike_decoder

Overview:
- Consumes the 14-bit signed membrane-voltage bus driven by the HH neuron wrapper and turns it into discrete spike events.
- Detects threshold crossings with hysteresis and a refractory hold-off.
- Measures inter-spike intervals (ISI) and buffers them in a small FIFO behind a valid/ready handshake.
- Sits downstream of the neuron, either on-chip or on an external board sampling uo_out/uio_out[7:2].

Parameters:
- V_W, 14, voltage bus width, two's-complement signed.
- ISI_W, 16, ISI counter and FIFO data width.
- FIFO_DEPTH, 4, ISI FIFO entries; power of two, at least 2.
- TH_HI, 500, signed rising threshold; a sample with v_in >= TH_HI fires a spike.
- TH_LO, -500, signed re-arm threshold; a sample with v_in < TH_LO ends the spike. Must satisfy TH_LO < TH_HI.
- REFRACT_CYC, 8, samples to hold off after re-arm; 0 means no hold-off.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- v_in  in  V_W  membrane voltage sample, signed.
- sample_en  in  1  v_in is valid this cycle; all counting and detection happen only on sample_en.
- spike_o  out  1  one-cycle spike pulse.
- spike_cnt  out  8  number of spikes detected, wraps at 255->0.
- isi_data  out  ISI_W  FIFO head: ISI in samples.
- isi_valid  out  1  FIFO not empty.
- isi_ready  in  1  consumer accepts the head this cycle.
- ovf  out  1  sticky flag: an ISI was dropped because the FIFO was full.
- ovf_clr  in  1  synchronous clear of ovf.

Behaviour:
- Reset (async, rst_n low): all outputs go to 0. State = BELOW. FIFO empty. isi_cnt = 0. first_seen = 0. Reset mid-operation discards FIFO contents and any in-progress refractory count.
- FSM. Transitions are evaluated only when sample_en = 1; with sample_en = 0 the state and all counters hold.
  - BELOW, v_in >= TH_HI: spike event; go to ABOVE.
  - ABOVE, v_in < TH_LO: go to REFRACT and load rcnt = REFRACT_CYC. If REFRACT_CYC = 0, go straight to BELOW.
  - REFRACT: decrement rcnt on each sample; when rcnt reaches 0, go to BELOW. Crossings during REFRACT are ignored.
- Comparisons are signed, full V_W width.
- Spike timing: a crossing sampled in cycle N gives spike_o = 1 in cycle N+1 only. spike_cnt increments in the same cycle N+1.
- ISI counting:
  - isi_cnt clears to 0 on each spike sample and increments on each subsequent sample_en.
  - It saturates at 2^ISI_W - 2, so the pushed value saturates at 2^ISI_W - 1.
  - On a spike sample with first_seen = 1, push isi_cnt + 1. Example: spikes on samples k and k+10 give ISI = 10.
  - The first spike after reset only sets first_seen and pushes nothing.
- FIFO:
  - Show-ahead. A push in cycle N+1 is visible as isi_valid = 1 with isi_data = value in cycle N+2.
  - Pop when isi_valid && isi_ready.
  - Push to a full FIFO is dropped and sets ovf, unless a pop occurs in the same cycle; in that case the push is accepted and there is no overflow.
  - Simultaneous push and pop on an empty FIFO: the pop is not possible, so the push is simply stored.
  - isi_data is don't-care while isi_valid = 0 and is driven to 0 in practice.
- ovf:
  - Set on a dropped push; cleared by ovf_clr.
  - If a set and ovf_clr occur in the same cycle, set wins.
- No combinational path from v_in to any output.

Decomposition:
- Shared package hh_pkg holds:
  - V_W default.
  - The state enum {BELOW, ABOVE, REFRACT}.
  - An ISI saturation-max constant function.
- Sub-module hh_isi_fifo:
  - Parameterised ISI_W and FIFO_DEPTH.
  - Synchronous push/pop, full/empty, show-ahead output, async active-low reset.
- The FSM, ISI counter and ovf logic live in the top-level block.

Test Plan:
- Reset/idle: hold rst_n = 0 for 3 cycles, then v_in = -1000 for 50 samples -> spike_o, spike_cnt, isi_valid and ovf stay 0.
- Hysteresis:
  - Drive v_in to 600, then 400, then 600, with no sample below -500 -> exactly 1 spike_o pulse, one cycle after the first 600 sample; spike_cnt = 1.
  - Then drive v_in = -600 for 9 samples and 600 again -> second spike; spike_cnt = 2.
- ISI and latency:
  - Periodic waveform with spikes at samples 10, 30 and 55, REFRACT_CYC = 8, isi_ready = 1.
  - Expected: FIFO outputs 20 then 25, each isi_valid two cycles after its spike sample. The first spike pushes nothing.
- Refractory: after re-arm, drive v_in = 700 on refractory samples 1..8 -> no spike. A 700 on the 9th sample -> spike.
- FIFO full/overflow:
  - With isi_ready = 0, generate 6 spikes -> 4 entries held, ovf = 1 after the 6th spike (5 ISIs pushed, 1 dropped).
  - Assert ovf_clr -> ovf = 0.
  - Hold isi_ready = 1 during a push while full -> no new ovf; entry count unchanged.
- sample_en gating and async reset:
  - Toggle sample_en at 50 % -> ISI is counted in samples, not cycles (spikes 10 samples apart give ISI = 10).
  - Assert rst_n mid-REFRACT with 2 FIFO entries -> all outputs 0 immediately. The first post-reset spike pushes nothing.
